// File: rtl/vector_arb_pkg.sv
// Shared definitions for the vector arbiter.
//   VEC_W        : width of one vector word delivered by the buffer.
//   arb_state_t  : arbiter FSM encoding (IDLE, ISSUE, WAIT, RESPOND).
//   retry_cnt_w  : width of the retry counter needed to count up to MAX_RETRY.
package vector_arb_pkg;

    localparam int VEC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    // At least one bit so the counter exists even when retries are disabled.
    function automatic int retry_cnt_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/vector_arbiter_if.sv
// Bundle of requester-side and buffer-side signals of the vector arbiter.
//   req        : per-requester level request
//   ack        : one-hot completion pulse
//   ack_ok     : 1 = vector delivered, 0 = miss (qualifies ack)
//   ack_vector : delivered vector, 0 unless ack with ack_ok
//   buf_req    : one-cycle poll strobe to the vector buffer
//   buf_vector : buffer data, one cycle after buf_req
//   buf_valid  : buffer data valid, same cycle as buf_vector
//   busy       : arbiter is inside a transaction
//
// Handshake: a requester raises req[i] and holds it until it sees ack[i]
// for exactly one cycle; the arbiter ignores req changes once a grant is
// latched. Each buf_req pulse is answered by the buffer in the following
// cycle with buf_valid/buf_vector; buf_valid at any other time is ignored.
interface vector_arbiter_if #(
    parameter int NB_REQ = 4
);
    import vector_arb_pkg::*;

    logic [NB_REQ-1:0] req;
    logic [NB_REQ-1:0] ack;
    logic              ack_ok;
    logic [VEC_W-1:0]  ack_vector;
    logic              buf_req;
    logic [VEC_W-1:0]  buf_vector;
    logic              buf_valid;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  req, buf_vector, buf_valid,
        output ack, ack_ok, ack_vector, buf_req, busy
    );

    // Environment side (requesters + buffer).
    modport master (
        output req, buf_vector, buf_valid,
        input  ack, ack_ok, ack_vector, buf_req, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : priority pointer; search starts here and wraps modulo NB_REQ
//   grant : index of the first set request at or after ptr
//   any   : at least one request is set (grant is 0 otherwise)
module rr_picker #(
    parameter int NB_REQ = 4
) (
    input  logic [NB_REQ-1:0]         req,
    input  logic [$clog2(NB_REQ)-1:0] ptr,
    output logic [$clog2(NB_REQ)-1:0] grant,
    output logic                      any
);
    localparam int IDX_W = $clog2(NB_REQ);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit at or
    // after ptr is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NB_REQ) begin
                idx = idx - NB_REQ;
            end
            if (req[idx]) begin
                grant = IDX_W'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/vector_arbiter.sv
// Round-robin arbiter sharing one vector buffer among NB_REQ requesters.
// A latched grant polls the buffer (ISSUE), samples its answer (WAIT),
// re-polls up to MAX_RETRY times on empty, then acknowledges the granted
// requester (RESPOND) with either the vector or a miss.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requester/buffer signal bundle (slave modport)
//   state_dbg  : current FSM state for observation
module vector_arbiter
    import vector_arb_pkg::*;
#(
    parameter int NB_REQ    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vector_arbiter_if.slave        bus,
    output arb_state_t             state_dbg
);
    localparam int IDX_W = $clog2(NB_REQ);
    localparam int RET_W = retry_cnt_w(MAX_RETRY);
    localparam logic [NB_REQ-1:0] ONE_HOT0 = NB_REQ'(1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [RET_W-1:0]  retry_q, retry_d;

    logic [NB_REQ-1:0] ack_q, ack_d;
    logic              ack_ok_q, ack_ok_d;
    logic [VEC_W-1:0]  ack_vector_q, ack_vector_d;
    logic              buf_req_q, buf_req_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              retry_left;

    rr_picker #(
        .NB_REQ (NB_REQ)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign retry_left = (32'(retry_q) < MAX_RETRY);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            retry_q      <= '0;
            ack_q        <= '0;
            ack_ok_q     <= 1'b0;
            ack_vector_q <= '0;
            buf_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            retry_q      <= retry_d;
            ack_q        <= ack_d;
            ack_ok_q     <= ack_ok_d;
            ack_vector_q <= ack_vector_d;
            buf_req_q    <= buf_req_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.buf_valid)   state_d = ST_RESPOND;
                else if (retry_left) state_d = ST_ISSUE;
                else                 state_d = ST_RESPOND;
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic. Every output is computed one cycle ahead
    // so that it appears registered in the cycle the FSM occupies the
    // matching state (buf_req with ISSUE, ack with RESPOND).
    always_comb begin
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        retry_d      = retry_q;
        ack_d        = '0;
        ack_ok_d     = 1'b0;
        ack_vector_d = '0;
        buf_req_d    = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_idx;
                    retry_d   = '0;
                    buf_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.buf_valid) begin
                    ack_d        = ONE_HOT0 << grant_q;
                    ack_ok_d     = 1'b1;
                    ack_vector_d = bus.buf_vector;
                end else if (retry_left) begin
                    retry_d   = retry_q + RET_W'(1);
                    buf_req_d = 1'b1;
                end else begin
                    ack_d = ONE_HOT0 << grant_q;
                end
            end
            ST_RESPOND: begin
                // Priority moves just past the requester that was served.
                ptr_d = (grant_q == IDX_W'(NB_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.ack        = ack_q;
    assign bus.ack_ok     = ack_ok_q;
    assign bus.ack_vector = ack_vector_q;
    assign bus.buf_req    = buf_req_q;
    assign bus.busy       = busy_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_vector_arbiter.sv
// Self-checking bench for vector_arbiter: requester stimulus, a reactive
// buffer model fed from a poll queue, and an ack scoreboard fed from an
// expected-transaction queue.
module tb_vector_arbiter;
    import vector_arb_pkg::*;

    localparam int NB_REQ    = 4;
    localparam int MAX_RETRY = 3;
    localparam int SB_W      = NB_REQ + 1 + VEC_W;

    logic       clk;
    logic       rst_n;
    arb_state_t state_dbg;

    vector_arbiter_if #(.NB_REQ(NB_REQ)) bus();

    vector_arbiter #(
        .NB_REQ    (NB_REQ),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit noise_en = 1'b0;

    logic [SB_W-1:0] exp_q[$];
    logic [VEC_W:0]  poll_q[$];

    int ack_cyc[16];
    int breq_cyc[16];
    int n_ack;
    int n_breq;

    // ---------------- clock / cycle counter / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- buffer model ----------------
    // Answers a poll one cycle after buf_req with the next queued response
    // (empty queue = not valid). With noise_en, unpolled cycles carry a
    // spurious valid that the arbiter must ignore.
    initial begin : buffer_model
        bit             polled;
        logic [VEC_W:0] p;
        bus.buf_valid  = 1'b0;
        bus.buf_vector = '0;
        forever begin
            @(negedge clk);
            polled = (bus.buf_req === 1'b1);
            @(posedge clk);
            #1;
            if (polled) begin
                if (poll_q.size() > 0) p = poll_q.pop_front();
                else                   p = {1'b0, 8'($urandom_range(0, 255))};
                bus.buf_valid  = p[VEC_W];
                bus.buf_vector = p[VEC_W-1:0];
            end else if (noise_en) begin
                bus.buf_valid  = 1'b1;
                bus.buf_vector = 8'($urandom_range(0, 255));
            end else begin
                bus.buf_valid  = 1'b0;
                bus.buf_vector = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin : scoreboard
        logic [SB_W-1:0] got;
        logic [SB_W-1:0] exp;
        bit              prev_breq;
        prev_breq = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ack !== '0) begin
                got = {bus.ack, bus.ack_ok, bus.ack_vector};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack got=%h required=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL ack_txn got=%h required=%h", got, exp);
                    end
                end
            end else begin
                checks++;
                if (bus.ack_ok !== 1'b0 || bus.ack_vector !== '0) begin
                    errors++;
                    $display("FAIL idle_ack_fields got=%b/%h required=0/00", bus.ack_ok, bus.ack_vector);
                end
            end
            if (bus.buf_req === 1'b1) begin
                checks++;
                if (prev_breq) begin
                    errors++;
                    $display("FAIL buf_req_consecutive got=1 required=0 cyc=%0d", cyc);
                end
            end
            prev_breq = (bus.buf_req === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_poll(input bit valid, input logic [VEC_W-1:0] data);
        poll_q.push_back({valid, data});
    endtask

    task automatic push_exp(input int idx, input bit ok, input logic [VEC_W-1:0] vec);
        logic [NB_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        exp_q.push_back({oh, ok, vec});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        poll_q.delete();
    endtask

    // Records cycles of buf_req and ack pulses until n acks or budget expiry.
    task automatic wait_acks(input int n, input int budget);
        n_ack  = 0;
        n_breq = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (bus.buf_req === 1'b1) begin
                if (n_breq < 16) breq_cyc[n_breq] = cyc;
                n_breq++;
            end
            if (bus.ack !== '0) begin
                if (n_ack < 16) ack_cyc[n_ack] = cyc;
                n_ack++;
            end
            if (n_ack >= n) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ack !== '0 || bus.buf_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got=ack%b/breq%b/busy%b required=0/0/0", bus.ack, bus.buf_req, bus.busy);
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d required=%0d", state_dbg, ST_IDLE);
        end
        @(posedge clk);
        #1;
        bus.req = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack_ok !== 1'b0 || bus.ack_vector !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=%b/%h/%b required=0/00/0", bus.ack_ok, bus.ack_vector, bus.busy);
        end
    endtask

    task automatic test_single_hit();
        int c0;
        do_reset();
        push_poll(1'b1, 8'hA5);
        push_exp(1, 1'b1, 8'hA5);
        @(posedge clk);
        #1;
        bus.req = 4'b0010;
        c0 = cyc;
        wait_acks(1, 20);
        checks++;
        if (n_ack !== 1) begin
            errors++;
            $display("FAIL hit_ack_count got=%0d required=1", n_ack);
        end
        checks++;
        if (ack_cyc[0] !== c0 + 3) begin
            errors++;
            $display("FAIL hit_latency got=%0d required=%0d", ack_cyc[0] - c0, 3);
        end
        checks++;
        if (n_breq !== 1 || breq_cyc[0] !== c0 + 1) begin
            errors++;
            $display("FAIL hit_buf_req got=%0d@%0d required=1@%0d", n_breq, breq_cyc[0] - c0, 1);
        end
        checks++;
        if (bus.busy !== 1'b1 || state_dbg !== ST_RESPOND) begin
            errors++;
            $display("FAIL hit_respond got=busy%b/st%0d required=1/%0d", bus.busy, state_dbg, ST_RESPOND);
        end
        @(posedge clk);
        #1;
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL hit_back_idle got=busy%b/st%0d required=0/%0d", bus.busy, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_fairness();
        int c0;
        logic [VEC_W-1:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            push_poll(1'b1, d);
            push_exp(i % NB_REQ, 1'b1, d);
        end
        @(posedge clk);
        #1;
        bus.req = 4'b1111;
        c0 = cyc;
        wait_acks(5, 40);
        bus.req = bus.req;
        checks++;
        if (n_ack !== 5) begin
            errors++;
            $display("FAIL fair_ack_count got=%0d required=5", n_ack);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ack_cyc[i] !== c0 + 3 + 4 * i) begin
                errors++;
                $display("FAIL fair_spacing[%0d] got=%0d required=%0d", i, ack_cyc[i] - c0, 3 + 4 * i);
            end
        end
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_miss();
        int c0;
        do_reset();
        push_exp(2, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        bus.req = 4'b0100;
        c0 = cyc;
        wait_acks(1, 30);
        checks++;
        if (n_ack !== 1 || ack_cyc[0] !== c0 + 3 + 2 * MAX_RETRY) begin
            errors++;
            $display("FAIL miss_latency got=%0d@%0d required=1@%0d", n_ack, ack_cyc[0] - c0, 3 + 2 * MAX_RETRY);
        end
        checks++;
        if (n_breq !== MAX_RETRY + 1) begin
            errors++;
            $display("FAIL miss_polls got=%0d required=%0d", n_breq, MAX_RETRY + 1);
        end
        for (int i = 0; i <= MAX_RETRY; i++) begin
            checks++;
            if (breq_cyc[i] !== c0 + 1 + 2 * i) begin
                errors++;
                $display("FAIL miss_poll_cyc[%0d] got=%0d required=%0d", i, breq_cyc[i] - c0, 1 + 2 * i);
            end
        end
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_late_hit();
        int c0;
        push_poll(1'b0, 8'($urandom_range(0, 255)));
        push_poll(1'b0, 8'($urandom_range(0, 255)));
        push_poll(1'b1, 8'h3C);
        push_exp(0, 1'b1, 8'h3C);
        @(posedge clk);
        #1;
        bus.req = 4'b0001;
        c0 = cyc;
        wait_acks(1, 30);
        checks++;
        if (n_ack !== 1 || ack_cyc[0] !== c0 + 7) begin
            errors++;
            $display("FAIL late_latency got=%0d@%0d required=1@7", n_ack, ack_cyc[0] - c0);
        end
        checks++;
        if (n_breq !== 3) begin
            errors++;
            $display("FAIL late_polls got=%0d required=3", n_breq);
        end
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_reset_mid_wait();
        int c0;
        push_poll(1'b1, 8'h77);
        @(posedge clk);
        #1;
        bus.req = 4'b0100;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_WAIT) begin
            errors++;
            $display("FAIL abort_in_wait got=%0d required=%0d", state_dbg, ST_WAIT);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = '0;
        poll_q.delete();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== '0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_idle got=busy%b/ack%b/st%0d required=0/0000/%0d", bus.busy, bus.ack, state_dbg, ST_IDLE);
        end
        repeat (3) @(posedge clk);
        push_poll(1'b1, 8'h5A);
        push_exp(3, 1'b1, 8'h5A);
        @(posedge clk);
        #1;
        bus.req = 4'b1000;
        c0 = cyc;
        wait_acks(1, 20);
        checks++;
        if (n_ack !== 1 || ack_cyc[0] !== c0 + 3) begin
            errors++;
            $display("FAIL abort_next_grant got=%0d@%0d required=1@3", n_ack, ack_cyc[0] - c0);
        end
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_early_drop();
        int c0;
        logic [VEC_W-1:0] d1;
        logic [VEC_W-1:0] d2;
        do_reset();
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        push_poll(1'b1, d1);
        push_poll(1'b1, d2);
        push_exp(2, 1'b1, d1);
        push_exp(3, 1'b1, d2);
        @(posedge clk);
        #1;
        bus.req = 4'b0100;
        c0 = cyc;
        @(posedge clk);
        #1;
        bus.req = 4'b1001;
        wait_acks(2, 30);
        checks++;
        if (n_ack !== 2) begin
            errors++;
            $display("FAIL drop_ack_count got=%0d required=2", n_ack);
        end
        checks++;
        if (ack_cyc[0] !== c0 + 3 || ack_cyc[1] !== c0 + 7) begin
            errors++;
            $display("FAIL drop_timing got=%0d,%0d required=3,7", ack_cyc[0] - c0, ack_cyc[1] - c0);
        end
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_random();
        int c0;
        int f;
        int polls;
        int idx;
        int tb_ptr;
        logic [NB_REQ-1:0] r;
        logic [VEC_W-1:0]  d;
        do_reset();
        tb_ptr = 0;
        for (int t = 0; t < 12; t++) begin
            r   = NB_REQ'($urandom_range(1, (1 << NB_REQ) - 1));
            f   = $urandom_range(0, MAX_RETRY + 1);
            d   = 8'($urandom_range(0, 255));
            idx = -1;
            for (int i = 0; i < NB_REQ; i++) begin
                if (idx < 0 && r[(tb_ptr + i) % NB_REQ]) idx = (tb_ptr + i) % NB_REQ;
            end
            for (int i = 0; i < f && i < MAX_RETRY + 1; i++) begin
                push_poll(1'b0, 8'($urandom_range(0, 255)));
            end
            if (f <= MAX_RETRY) begin
                push_poll(1'b1, d);
                push_exp(idx, 1'b1, d);
                polls = f + 1;
            end else begin
                push_exp(idx, 1'b0, 8'h00);
                polls = MAX_RETRY + 1;
            end
            @(posedge clk);
            #1;
            bus.req = r;
            c0 = cyc;
            wait_acks(1, 30);
            checks++;
            if (n_ack !== 1 || ack_cyc[0] !== c0 + 1 + 2 * polls || n_breq !== polls) begin
                errors++;
                $display("FAIL rand[%0d] got=%0d@%0d/%0d polls required=1@%0d/%0d polls", t, n_ack, ack_cyc[0] - c0, n_breq, 1 + 2 * polls, polls);
            end
            tb_ptr = (idx + 1) % NB_REQ;
            @(posedge clk);
            #1;
            bus.req = '0;
            poll_q.delete();
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        test_reset();
        noise_en = 1'b1;
        test_single_hit();
        test_fairness();
        test_miss();
        test_late_hit();
        test_reset_mid_wait();
        test_early_drop();
        test_random();
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
